mem_responder: RTL and testbench

//  Memory-side responder for the core req/gnt memory interface (imem or dmem

---
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the req/gnt memory interface: fixed-latency grant
// from a word-addressed RAM, plus a sticky checker for initiator protocol errors.
module mem_responder #(
   parameter int unsigned   AW        = 64,
   parameter int unsigned   DW        = 64,
   parameter int unsigned   DEPTH     = 1024,
   parameter logic [AW-1:0] BASE_ADDR = '0,
   parameter int unsigned   LATENCY   = 1
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            mem_req,
   input  logic [AW-1:0]   mem_addr,
   input  logic            mem_wen,
   input  logic [DW/8-1:0] mem_strb,
   input  logic [DW-1:0]   mem_wdata,
   output logic            mem_gnt,
   output logic            mem_err,
   output logic [DW-1:0]   mem_rdata,
   output logic            proto_err,
   output logic [1:0]      dbg_state
);
   localparam int unsigned SW = DW / 8;
   localparam int unsigned BW = $clog2(SW);
   localparam int unsigned IW = $clog2(DEPTH);

   // Handshake: the initiator raises mem_req with stable addr/wen/strb/wdata and
   // holds it until mem_gnt (one-cycle pulse); the transfer completes on the edge
   // closing the gnt cycle, so a req still high then belongs to that transfer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   cap_addr;
   logic            cap_wen;
   logic [SW-1:0]   cap_strb;
   logic [DW-1:0]   cap_wdata;
   logic            capture;
   logic            enter_resp;
   logic            do_write;
   logic            proto_hit;
   logic            mismatch;
   logic [AW-1:0]   x_addr;
   logic            x_wen;
   logic [SW-1:0]   x_strb;
   logic [DW-1:0]   x_wdata;
   logic [AW-1:0]   x_word;
   logic [IW-1:0]   x_idx;
   logic            x_err;
   logic            gnt_d;
   logic            err_d;
   logic [DW-1:0]   rdata_d;
   logic [DW-1:0]   ram [DEPTH];

   assign mismatch  = (mem_addr != cap_addr) || (mem_wen != cap_wen) ||
                      (mem_strb != cap_strb) || (mem_wdata != cap_wdata);
   assign dbg_state = state_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      capture    = 1'b0;
      enter_resp = 1'b0;
      proto_hit  = 1'b0;
      // With zero latency the RAM access happens on the capture edge itself,
      // so the live inputs stand in for the not-yet-loaded capture registers.
      x_addr     = cap_addr;
      x_wen      = cap_wen;
      x_strb     = cap_strb;
      x_wdata    = cap_wdata;
      case (state_q)
         IDLE: begin
            x_addr  = mem_addr;
            x_wen   = mem_wen;
            x_strb  = mem_strb;
            x_wdata = mem_wdata;
            if (mem_req) begin
               capture = 1'b1;
               cnt_d   = 4'(LATENCY);
               if (LATENCY == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            proto_hit = !mem_req || mismatch;
            if (!mem_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 4'd1) begin
               state_d    = RESP;
               enter_resp = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            proto_hit = !mem_req || mismatch;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      x_word   = (x_addr - BASE_ADDR) >> BW;
      x_idx    = x_word[IW-1:0];
      x_err    = (x_addr < BASE_ADDR) || (x_word >= AW'(DEPTH)) ||
                 (x_addr[BW-1:0] != '0);
      do_write = enter_resp && x_wen && !x_err;
      gnt_d    = enter_resp;
      err_d    = enter_resp && x_err;
      rdata_d  = (enter_resp && !x_wen && !x_err) ? ram[x_idx] : '0;
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         cap_addr  <= '0;
         cap_wen   <= 1'b0;
         cap_strb  <= '0;
         cap_wdata <= '0;
         mem_gnt   <= 1'b0;
         mem_err   <= 1'b0;
         mem_rdata <= '0;
         proto_err <= 1'b0;
      end else begin
         if (capture) begin
            cap_addr  <= mem_addr;
            cap_wen   <= mem_wen;
            cap_strb  <= mem_strb;
            cap_wdata <= mem_wdata;
         end
         mem_gnt   <= gnt_d;
         mem_err   <= err_d;
         mem_rdata <= rdata_d;
         if (proto_hit) begin
            proto_err <= 1'b1;
         end
      end
   end

   // RAM is deliberately outside reset so its contents survive g_reset.
   always_ff @(posedge g_clk) begin
      if (do_write && !g_reset) begin
         for (int b = 0; b < SW; b++) begin
            if (x_strb[b]) begin
               ram[x_idx][b*8 +: 8] <= x_wdata[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 0, 3) driven by directed
// and random transfers, checked every cycle against a word-array memory model.
module tb_mem_responder;
   localparam int NU    = 3;
   localparam int DEPTH = 1024;
   localparam int NEVER = 32'h7fff_ffff;

   typedef struct packed {
      int          cyc;
      logic        err;
      logic        chk;
      logic [63:0] rdata;
   } exp_t;

   logic                  clk = 1'b0;
   logic [NU-1:0]         rst;
   logic [NU-1:0]         req;
   logic [NU-1:0]         wen_s;
   logic [NU-1:0][63:0]   addr_s;
   logic [NU-1:0][63:0]   wdata_s;
   logic [NU-1:0][7:0]    strb_s;
   wire  [NU-1:0]         gnt;
   wire  [NU-1:0]         err;
   wire  [NU-1:0]         proto;
   wire  [NU-1:0][63:0]   rdata;
   wire  [NU-1:0][1:0]    dbg;

   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;
   int          proto_from [NU];
   logic [63:0] mm [NU][DEPTH];
   bit          known [NU][DEPTH];
   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   exp_t        exp_q2[$];

   // clock / cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NU; g++) begin : g_dut
      mem_responder #(.LATENCY(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
         .g_clk     (clk),
         .g_reset   (rst[g]),
         .mem_req   (req[g]),
         .mem_addr  (addr_s[g]),
         .mem_wen   (wen_s[g]),
         .mem_strb  (strb_s[g]),
         .mem_wdata (wdata_s[g]),
         .mem_gnt   (gnt[g]),
         .mem_err   (err[g]),
         .mem_rdata (rdata[g]),
         .proto_err (proto[g]),
         .dbg_state (dbg[g])
      );
   end

   function automatic int lat(input int u);
      return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
   endfunction

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // scoreboard queues
   function automatic void push_exp(input int u, input exp_t e);
      case (u)
         0:       exp_q0.push_back(e);
         1:       exp_q1.push_back(e);
         default: exp_q2.push_back(e);
      endcase
   endfunction

   function automatic void flush_exp(input int u);
      case (u)
         0:       exp_q0.delete();
         1:       exp_q1.delete();
         default: exp_q2.delete();
      endcase
   endfunction

   function automatic bit pop_due(input int u, output exp_t e);
      e = '0;
      case (u)
         0: if (exp_q0.size() > 0 && exp_q0[0].cyc == cyc) begin e = exp_q0.pop_front(); return 1'b1; end
         1: if (exp_q1.size() > 0 && exp_q1[0].cyc == cyc) begin e = exp_q1.pop_front(); return 1'b1; end
         default: if (exp_q2.size() > 0 && exp_q2[0].cyc == cyc) begin e = exp_q2.pop_front(); return 1'b1; end
      endcase
      return 1'b0;
   endfunction

   // memory model: grant lands LATENCY+1 cycles after the request is raised
   function automatic exp_t predict(input int u, input bit w, input logic [63:0] a,
                                    input logic [7:0] s, input logic [63:0] d);
      exp_t        e;
      int          idx;
      logic [63:0] word;
      e.cyc   = cyc + 1 + lat(u);
      e.err   = 1'b0;
      e.chk   = 1'b1;
      e.rdata = '0;
      if ((a % 8) != 0 || (a / 8) >= DEPTH) begin
         e.err = 1'b1;
      end else begin
         idx = int'(a / 8);
         if (w) begin
            word = mm[u][idx];
            for (int b = 0; b < 8; b++) begin
               if (s[b]) word[8*b +: 8] = d[8*b +: 8];
            end
            mm[u][idx] = word;
            if (s == 8'hFF) known[u][idx] = 1'b1;
         end else begin
            e.rdata = mm[u][idx];
            e.chk   = known[u][idx];
         end
      end
      return e;
   endfunction

   // per-cycle compare
   always @(negedge clk) begin : cmp
      exp_t e;
      bit   due;
      for (int u = 0; u < NU; u++) begin
         due = pop_due(u, e);
         check($sformatf("gnt_u%0d", u), gnt[u], due);
         if (due) begin
            check($sformatf("err_u%0d", u), err[u], e.err);
            if (e.chk) check($sformatf("rdata_u%0d", u), rdata[u], e.rdata);
         end
         check($sformatf("proto_u%0d", u), proto[u], (cyc >= proto_from[u]) ? 1 : 0);
      end
   end

   // drivers
   task automatic idle(input int u, input int n);
      req[u] = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_xfer(input int u, input bit w, input logic [63:0] a, input logic [7:0] s,
                          input logic [63:0] d, output logic [63:0] g_rdata, output logic g_err,
                          output int g_cyc, output int i_cyc);
      req[u]     = 1'b1;
      wen_s[u]   = w;
      addr_s[u]  = a;
      strb_s[u]  = s;
      wdata_s[u] = d;
      i_cyc      = cyc;
      push_exp(u, predict(u, w, a, s, d));
      g_cyc   = -1;
      g_rdata = '0;
      g_err   = 1'b0;
      for (int n = 0; n < 24 && g_cyc < 0; n++) begin
         @(negedge clk);
         if (gnt[u]) begin
            g_rdata = rdata[u];
            g_err   = err[u];
            g_cyc   = cyc;
         end
      end
      check($sformatf("gnt_seen_u%0d", u), (g_cyc >= 0) ? 1 : 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input int u, input bit w, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d);
      logic [63:0] rd;
      logic        er;
      int          gc, ic;
      do_xfer(u, w, a, s, d, rd, er, gc, ic);
   endtask

   initial begin
      logic [63:0] rd, a;
      logic        er;
      int          gc, ic, prev, k;

      rst     = '1;
      req     = '0;
      wen_s   = '0;
      addr_s  = '0;
      strb_s  = '0;
      wdata_s = '0;
      for (int u = 0; u < NU; u++) proto_from[u] = NEVER;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         check("rst_gnt", gnt[u], 0);
         check("rst_err", err[u], 0);
         check("rst_rdata", rdata[u], 0);
         check("rst_proto", proto[u], 0);
         check("rst_state", dbg[u], 0);
      end
      @(posedge clk);
      #1;
      rst = '0;

      // basic write/read at latency 1
      do_xfer(0, 1'b1, 64'h10, 8'hFF, 64'h1122334455667788, rd, er, gc, ic);
      check("t1_wr_lat", gc - ic, 2);
      check("t1_wr_err", er, 0);
      check("t1_wr_rdata", rd, 0);
      do_xfer(0, 1'b0, 64'h10, 8'h00, 64'h0, rd, er, gc, ic);
      check("t1_rd_lat", gc - ic, 2);
      check("t1_rd_err", er, 0);
      check("t1_rd_data", rd, 64'h1122334455667788);

      // strobe merge
      xfer(0, 1'b1, 64'h8, 8'hFF, '1);
      xfer(0, 1'b1, 64'h8, 8'h0F, 64'h0);
      do_xfer(0, 1'b0, 64'h8, 8'h00, 64'h0, rd, er, gc, ic);
      check("t2_merge", rd, 64'hFFFFFFFF00000000);

      // decode errors
      xfer(0, 1'b1, 64'h0, 8'hFF, 64'hA5A5A5A5A5A5A5A5);
      do_xfer(0, 1'b0, 64'(DEPTH * 8), 8'h00, 64'h0, rd, er, gc, ic);
      check("t3_oob_err", er, 1);
      check("t3_oob_rdata", rd, 0);
      do_xfer(0, 1'b0, 64'h4, 8'h00, 64'h0, rd, er, gc, ic);
      check("t3_mis_err", er, 1);
      do_xfer(0, 1'b1, 64'h3, 8'hFF, 64'h0, rd, er, gc, ic);
      check("t3_wmis_err", er, 1);
      check("t3_wmis_rdata", rd, 0);
      do_xfer(0, 1'b0, 64'h0, 8'h00, 64'h0, rd, er, gc, ic);
      check("t3_word0", rd, 64'hA5A5A5A5A5A5A5A5);
      idle(0, 1);

      // back-to-back throughput at latency 0 and 3
      for (int u = 1; u < NU; u++) begin
         prev = 0;
         for (int i = 0; i < 4; i++) begin
            do_xfer(u, (i < 2), 64'(8 * (i % 2)), 8'hFF, {$urandom, $urandom}, rd, er, gc, ic);
            if (i > 0) check($sformatf("t4_gap_u%0d", u), gc - prev, lat(u) + 2);
            prev = gc;
         end
         idle(u, 1);
         check($sformatf("t4_proto_u%0d", u), proto[u], 0);
      end

      // dropped request in WAIT aborts the write
      xfer(2, 1'b1, 64'h20, 8'hFF, 64'h0123456789ABCDEF);
      idle(2, 1);
      req[2] = 1'b1; wen_s[2] = 1'b1; addr_s[2] = 64'h20; strb_s[2] = 8'hFF;
      wdata_s[2] = 64'hBAD0BAD0BAD0BAD0;
      k = cyc;
      @(posedge clk);
      #1;
      req[2] = 1'b0;
      proto_from[2] = k + 2;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("t5_proto", proto[2], 1);
      do_xfer(2, 1'b0, 64'h20, 8'h00, 64'h0, rd, er, gc, ic);
      check("t5_readback", rd, 64'h0123456789ABCDEF);
      idle(2, 1);

      // reset during WAIT discards the pending write
      xfer(2, 1'b1, 64'h28, 8'hFF, 64'h5555AAAA5555AAAA);
      idle(2, 1);
      req[2] = 1'b1; wen_s[2] = 1'b1; addr_s[2] = 64'h28; strb_s[2] = 8'hFF;
      wdata_s[2] = 64'hFFFF0000FFFF0000;
      @(posedge clk);
      #1;
      rst[2] = 1'b1;
      req[2] = 1'b0;
      flush_exp(2);
      proto_from[2] = NEVER;
      #1;
      check("t6_gnt", gnt[2], 0);
      check("t6_state", dbg[2], 0);
      check("t6_proto", proto[2], 0);
      @(posedge clk);
      #1;
      rst[2] = 1'b0;
      do_xfer(2, 1'b0, 64'h28, 8'h00, 64'h0, rd, er, gc, ic);
      check("t6_readback", rd, 64'h5555AAAA5555AAAA);
      check("t6_lat", gc - ic, 4);
      idle(2, 1);

      // random traffic over a 16-word window plus error addresses
      for (int u = 0; u < NU; u++) begin
         for (int i = 0; i < 16; i++) xfer(u, 1'b1, 64'(8 * i), 8'hFF, {$urandom, $urandom});
         for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
               0:       a = 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(1, 7));
               1:       a = 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 100));
               2:       a = {32'hFFFF_FFFF, $urandom} & ~64'h7;
               default: a = 64'(8 * $urandom_range(0, 15));
            endcase
            xfer(u, $urandom_range(0, 1) == 1, a, 8'($urandom), {$urandom, $urandom});
            if ($urandom_range(0, 2) != 0) idle(u, $urandom_range(1, 2));
         end
         idle(u, 1);
      end

      repeat (6) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
